// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encodings,
// instruction opcode/funct constants and the 4-bit ALU operation codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXE  = 4'd6,
    ITEXE  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10
  } state_t;

  // opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct field (instruction[5:0])
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;
  localparam logic [3:0] ALU_LUI = 4'b1100;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU operation decoder (combinational).
//   state         : current control state
//   opcode/funct  : instruction fields from the IR
//   alu_oper      : ALU operation for this state (ADD unless the state says otherwise)
//   illegal_funct : high in RTEXE when funct is not a supported R-type op
module mips_alu_dec
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_oper,
  output logic       illegal_funct
);

  always_comb begin
    alu_oper      = ALU_ADD;
    illegal_funct = 1'b0;
    case (state)
      RTEXE: begin
        case (funct)
          FN_ADD:  alu_oper = ALU_ADD;
          FN_SUB:  alu_oper = ALU_SUB;
          FN_AND:  alu_oper = ALU_AND;
          FN_OR:   alu_oper = ALU_OR;
          FN_XOR:  alu_oper = ALU_XOR;
          FN_SLT:  alu_oper = ALU_SLT;
          FN_SLL:  alu_oper = ALU_SLL;
          FN_SRL:  alu_oper = ALU_SRL;
          default: illegal_funct = 1'b1;
        endcase
      end
      ITEXE: begin
        case (opcode)
          OP_ANDI: alu_oper = ALU_AND;
          OP_ORI:  alu_oper = ALU_OR;
          OP_LUI:  alu_oper = ALU_LUI;
          default: alu_oper = ALU_ADD;
        endcase
      end
      BRANCH:  alu_oper = ALU_SUB;
      default: alu_oper = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control FSM (Moore, except FETCH enables follow mem_ready
// and BRANCH pc_en follows zero).
//   clk, rst_n            : clock, async active-low reset
//   opcode, funct         : IR fields; zero : ALU zero flag; mem_ready : memory done
//   alu_oper/src_a/src_b  : ALU controls
//   pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
//   pc_src                : datapath enables and selects
//   illegal               : pulse when leaving DECODE/RTEXE on unsupported opcode/funct
//   state_dbg             : current state encoding
module mips_ctrl_fsm
  import mips_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_oper,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state, nxt;
  logic   reg_dst_q;
  logic   illegal_funct;
  logic   rdy;

  assign rdy       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state_dbg = state;

  mips_alu_dec u_alu_dec (
    .state         (state),
    .opcode        (opcode),
    .funct         (funct),
    .alu_oper      (alu_oper),
    .illegal_funct (illegal_funct)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= nxt;
  end

  // destination select captured on the way into ALUWB: rd for R-type, rt for I-type
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              reg_dst_q <= 1'b0;
    else if (state == RTEXE) reg_dst_q <= 1'b1;
    else if (state == ITEXE) reg_dst_q <= 1'b0;
  end

  always_comb begin
    nxt        = state;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 2'd0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = rdy;
        pc_en     = rdy;
        if (rdy) nxt = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd2;
        case (opcode)
          OP_LW, OP_SW:                    nxt = MEMADR;
          OP_RTYPE:                        nxt = RTEXE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nxt = ITEXE;
          OP_BEQ:                          nxt = BRANCH;
          OP_J:                            nxt = JUMP;
          default: begin
            nxt     = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        nxt       = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (rdy) nxt = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt        = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (rdy) nxt = FETCH;
      end
      RTEXE: begin
        alu_src_a = 1'b1;
        illegal   = illegal_funct;
        nxt       = illegal_funct ? FETCH : ALUWB;
      end
      ITEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = (opcode == OP_ANDI || opcode == OP_ORI) ? 2'd3 : 2'd2;
        nxt       = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = reg_dst_q;
        nxt       = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = 2'd1;
        pc_en     = zero;
        nxt       = FETCH;
      end
      JUMP: begin
        pc_src = 2'd2;
        pc_en  = 1'b1;
        nxt    = FETCH;
      end
      default: nxt = FETCH;
    endcase
    // state is already FETCH during reset; keep its rdy-driven enables quiet too
    if (!rst_n) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning 1 = memory states wait for mem_ready, 0 = mem_ready ignored and treated as 1.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instruction[5:0] from the instruction register.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-008 SHALL have port alu_oper  output  4  ALU operation code.
REQ-009 SHALL have port alu_src_a  output  1  0 = PC, 1 = register A.
REQ-010 SHALL have port alu_src_b  output  2  0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = zero-extended immediate.
REQ-011 SHALL have ports pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg  output  1 each  datapath enables and selects.
REQ-012 SHALL have port pc_src  output  2  0 = ALU result, 1 = ALU-out register, 2 = jump target.
REQ-013 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
REQ-014 SHALL have port state_dbg  output  4  current state encoding.

Function
REQ-015 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ITEXE, ALUWB, BRANCH, JUMP.
REQ-016 FETCH: mem_read=1, iord=0, ir_write=mem_ready, alu_src_a=0, alu_src_b=1, alu_oper=0101, pc_src=0, pc_en=mem_ready; stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-017 DECODE: alu_src_a=0, alu_src_b=2, alu_oper=0101 (branch target precompute); next state: lw/sw->MEMADR, R-type->RTEXE, addi/andi/ori/lui->ITEXE, beq->BRANCH, j->JUMP, any other opcode->FETCH with illegal=1.
REQ-018 MEMADR: alu_src_a=1, alu_src_b=2, alu_oper=0101; lw (100011)->MEMRD, sw (101011)->MEMWR.
REQ-019 MEMRD: mem_read=1, iord=1; waits for mem_ready, then goes to MEMWB. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
REQ-020 MEMWR: mem_write=1, iord=1; waits for mem_ready, then goes to FETCH.
REQ-021 RTEXE: alu_src_a=1, alu_src_b=0; funct mapping: 100000->0101, 100010->0110, 100100->0001, 100101->0011, 100110->0010, 101010->1000, 000000->1010, 000010->1011.
REQ-022 RTEXE: an unmapped funct SHALL pulse illegal, suppress the write, and go to FETCH; a mapped funct goes to ALUWB with reg_dst=1.
REQ-023 ITEXE: alu_src_a=1; addi(001000) uses alu_src_b=2 with alu_oper 0101; andi(001100) uses alu_src_b=3 with 0001; ori(001101) uses alu_src_b=3 with 0011; lui(001111) uses alu_src_b=2 with 1100. Next state is ALUWB with reg_dst=0.
REQ-024 ALUWB: reg_write=1, mem_to_reg=0; reg_dst is held from the preceding state in a 1-bit register; then FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=0, alu_oper=0110, pc_src=1, pc_en=zero; then FETCH.
REQ-026 JUMP: pc_src=2, pc_en=1; then FETCH.
REQ-027 Every output not listed for a state SHALL be 0, including alu_oper=0101 as the default code.
REQ-028 Latencies with mem_ready held at 1: lw 5 cycles, sw 4, R-type 4, I-type 4, beq 3, j 3.
REQ-029 A mem_ready pulse outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-030 illegal SHALL be asserted for exactly one cycle, in the cycle the FSM leaves DECODE or RTEXE.

Reset
REQ-031 While rst_n=0, state SHALL be FETCH immediately (asynchronously), the reg_dst register SHALL be 0, and illegal SHALL be 0.
REQ-032 Asserting rst_n in the middle of an instruction SHALL abort it with no further reg_write, mem_write or pc_en.
REQ-033 After rst_n deasserts, the first edge SHALL evaluate FETCH.

Structure
REQ-034 A shared package mips_pkg SHALL hold the state encodings (FETCH=0 … JUMP=10), the opcode and funct constants, and the 4-bit ALU operation codes.
REQ-035 The design SHALL contain one sub-module, mips_alu_dec: combinational mapping of opcode/funct/state to alu_oper and illegal_funct.

Verification
REQ-036 Reset sequence: rst_n=0 asserted mid-MEMRD -> state_dbg=0 immediately and all enables=0.
REQ-037 lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4 over 5 cycles, reg_write=1 only in MEMWB, mem_to_reg=1.
REQ-038 sub (funct 100010), then slt (funct 101010) -> alu_oper=0110 then 1000 in RTEXE, reg_dst=1 in ALUWB.
REQ-039 beq with zero=1 -> pc_en=1 and pc_src=1 in BRANCH; with zero=0 -> pc_en=0.
REQ-040 sw with mem_ready low for 3 cycles -> FSM holds MEMWR with mem_write=1 for 4 cycles, then FETCH.
REQ-041 opcode 111111 -> illegal=1 for one cycle, then FETCH with no write; R-type funct 000111 -> same behaviour.
